// File: rtl/passivator_nd_sync.sv
// Clocked passivator joining two active 4-phase handshake ports with synchronised requests.
// Define PASSIVATOR_XFER_CNT_EN to add the xfer_cnt completed-transfer counter output.
`timescale 1ns/1ps

module passivator_nd_sync #(
   parameter int DWIDTH      = 8,
   parameter int NWORDS      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req1,
   output logic                     ack1,
   input  logic [NWORDS*DWIDTH-1:0] data_in,
   input  logic                     req2,
   output logic                     ack2,
   output logic [NWORDS*DWIDTH-1:0] data_out
`ifdef PASSIVATOR_XFER_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]     xfer_cnt
`endif
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [NWORDS*DWIDTH-1:0]   data_q, data_d;
   logic                       capture;
   logic                       ack;
   logic                       r1s, r2s;

   if (NWORDS < 1 || SYNC_STAGES < 0 || CNT_WIDTH < 1) begin : g_param_err
      $error("passivator_nd_sync: illegal parameter value");
   end

   // Bit 0 of each stage carries req1, bit 1 carries req2.
   if (SYNC_STAGES == 0) begin : g_bypass
      assign r1s = req1;
      assign r2s = req2;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;

      always_comb begin
         sync_d[0] = {req2, req1};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
         end
      end

      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sync_q <= '0;
         else        sync_q <= sync_d;
      end

      assign r1s = sync_q[SYNC_STAGES-1][0];
      assign r2s = sync_q[SYNC_STAGES-1][1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: if (r1s && r2s) begin
            state_d = ST_ACK;
            capture = 1'b1;
         end
         ST_ACK:  if (!r1s && !r2s) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d = capture ? data_in : data_q;
   end

   // Both acks decode the single state flop, so they match and cannot glitch.
   always_comb begin
      ack = (state_q == ST_ACK);
   end

   assign ack1     = ack;
   assign ack2     = ack;
   assign data_out = data_q;

`ifdef PASSIVATOR_XFER_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Counts return-to-zero completions; wraps freely.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_ACK && !r1s && !r2s) cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: doc/passivator_nd_sync.md
Name: passivator_nd_sync

Overview:
- Clocked, parametrised successor to the combinational 4-word passivator.
- Joins two active 4-phase handshake ports: producer side (req1/ack1) pushes data, consumer side (req2/ack2) pulls it.
- Width and word count are parameters. Request inputs are synchronised.
- Data is captured into a register so data_out stays stable for the whole handshake. Sits between asynchronous or cross-domain handshake stages and the clocked datapath.

Parameters:
- DWIDTH, 8, bits per data word.
- NWORDS, 4, number of data words per transfer (>=1).
- SYNC_STAGES, 2, flops per request synchroniser; 0 = bypass (requests already synchronous).
- CNT_WIDTH, 16, width of transfer counter (used only with optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req1  input  1  producer request (4-phase).
- ack1  output  1  producer acknowledge.
- data_in  input  NWORDS*DWIDTH  producer data; word k = bits [k*DWIDTH +: DWIDTH]; stable while req1 high.
- req2  input  1  consumer request (4-phase).
- ack2  output  1  consumer acknowledge.
- data_out  output  NWORDS*DWIDTH  registered data, same word packing.
- xfer_cnt  output  CNT_WIDTH  completed-transfer count (only with PASSIVATOR_XFER_CNT_EN).

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low. While rst_n=0: ack1=0, ack2=0, data_out=0, synchroniser flops=0, state=IDLE, xfer_cnt=0.
- Synchronisation: req1/req2 each pass through SYNC_STAGES flops, giving r1s/r2s. With SYNC_STAGES=0, r1s=req1 and r2s=req2 directly.
- ack1 and ack2 come from one state register; they are always equal and glitch-free.
- IDLE (ack=0):
  - r1s & r2s: capture data_in into data_out, go to ACK.
  - Otherwise stay. A single request waits indefinitely; nothing is captured.
- ACK (ack=1):
  - !r1s & !r2s: go to IDLE, increment xfer_cnt.
  - Otherwise stay. One request dropping early keeps ack high until the other also drops. Re-raising a request while still in ACK causes no new capture.
- Latency:
  - ack rises at the (SYNC_STAGES+1)th rising edge after both requests are high and setup-stable. data_out updates on that same edge.
  - ack falls at the (SYNC_STAGES+1)th edge after both requests are low.
  - Minimum cycle per transfer: 2*(SYNC_STAGES+1) clocks.
- data_out holds its value between captures. It is not cleared on the return-to-zero phase.
- Simultaneous events:
  - req1 and req2 rising on the same edge is treated the same as staggered rising.
  - The capture edge is the first edge at which both synchronised requests are high.
- Reset mid-handshake: ack drops immediately (asynchronously) and data_out clears. After reset releases, a new transfer starts only once both synchronised requests are seen high from IDLE. Requests still high at release cause a new capture after SYNC_STAGES+1 edges; the environment must tolerate this.
- xfer_cnt wraps modulo 2^CNT_WIDTH with no saturation.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PASSIVATOR_XFER_CNT_EN.
- Defined: xfer_cnt port exists. It increments by 1 on each ACK->IDLE transition and resets to 0.
- Undefined: xfer_cnt port and counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset with DWIDTH=8, NWORDS=4, SYNC_STAGES=2, data_in=0xDEADBEEF, req1=req2=1 -> during reset ack1=ack2=0, data_out=0. After release, ack=1 on 3rd edge and data_out=0xDEADBEEF.
2. Full handshake, data_in=0x11223344 -> ack high 3 edges after both reqs high; change data_in to 0x55667788 while ack=1 -> data_out stays 0x11223344. Drop both reqs -> ack low 3 edges later.
3. Staggered requests: req1 high, req2 held low for 10 cycles -> ack stays 0 and data_out unchanged. Raise req2 -> ack rises 3 edges later.
4. Early drop: in ACK, drop req1 only, hold req2 for 5 cycles -> ack stays 1. Drop req2 -> ack falls 3 edges later.
5. Reset asserted mid-ACK -> ack1/ack2/data_out go to 0 before the next clock edge. Hold reqs low, release -> state IDLE, no capture.
6. With PASSIVATOR_XFER_CNT_EN, CNT_WIDTH=4: run 17 transfers -> xfer_cnt=1 (wrapped). With SYNC_STAGES=0, ack rises 1 edge after both reqs high.
